echo_gate_peak: RTL and testbench

- Measurement stage directly downstream of the ADC dual-sample wrapper, upstream of the 8-digit numeric display.
- On each trigger (IR-remote interrupt or auto start), it skips a blanking window of samples, then scans a fixed-length gate window.
- Within the gate it reports the peak amplitude, the peak's sample index and the first threshold-crossing index (echo time-of-flight).
- Results are held stable for the display until the next measurement completes.

---
 rtl/echo_gate_peak_pkg.sv | 10 +
 rtl/echo_gate_peak_pair_max_cmp.sv | 45 ++++
 rtl/echo_gate_peak.sv | 113 +++++++++++
 tb/tb_echo_gate_peak.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/echo_gate_peak_pkg.sv
// echo_gate_peak_pkg: FSM encoding and gate range check shared by the measurement stages.
package echo_gate_peak_pkg;

   typedef enum logic [1:0] {IDLE, SKIP, GATE, DONE} state_t;

   function automatic logic gated(input int unsigned k, input int unsigned start, input int unsigned len);
      return (k >= start) && (k < start + len);
   endfunction

endpackage

// File: rtl/echo_gate_peak_pair_max_cmp.sv
// pair_max_cmp: folds one sample pair (earlier sample first) into the running peak/first-crossing state.
module pair_max_cmp #(
   parameter int W = 8,
   parameter int IW = 16,
   parameter int THRESHOLD = 128
) (
   input  logic [W-1:0]  s0,
   input  logic [W-1:0]  s1,
   input  logic [IW-1:0] k0,
   input  logic [IW-1:0] k1,
   input  logic          g0,
   input  logic          g1,
   input  logic [W-1:0]  peak,
   input  logic [IW-1:0] peak_idx,
   input  logic [IW-1:0] first_idx,
   input  logic          found,
   input  logic          have,
   output logic [W-1:0]  peak_nx,
   output logic [IW-1:0] idx_nx,
   output logic [IW-1:0] first_nx,
   output logic          found_nx,
   output logic          have_nx
);
   logic          take0, take1, hit0, hit1, found_a, have_a;
   logic [W-1:0]  peak_a;
   logic [IW-1:0] idx_a, first_a;

   // strict greater keeps the earliest index on ties; "have" lets the first gated sample load even at 0
   assign take0   = g0 && (!have || s0 > peak);
   assign peak_a  = take0 ? s0 : peak;
   assign idx_a   = take0 ? k0 : peak_idx;
   assign have_a  = have | g0;
   assign hit0    = g0 && !found && s0 >= W'(THRESHOLD);
   assign found_a = found | hit0;
   assign first_a = hit0 ? k0 : first_idx;

   assign take1    = g1 && (!have_a || s1 > peak_a);
   assign peak_nx  = take1 ? s1 : peak_a;
   assign idx_nx   = take1 ? k1 : idx_a;
   assign have_nx  = have_a | g1;
   assign hit1     = g1 && !found_a && s1 >= W'(THRESHOLD);
   assign found_nx = found_a | hit1;
   assign first_nx = hit1 ? k1 : first_a;

endmodule

// File: rtl/echo_gate_peak.sv
// echo_gate_peak: after a trigger, skips a blanking window and reports peak, peak index and
// first threshold crossing within a fixed gate of a dual-sample stream.
module echo_gate_peak
   import echo_gate_peak_pkg::*;
#(
   parameter int AD_DATA_WIDTH = 8,
   parameter int IDX_WIDTH = 16,
   parameter int GATE_START = 16,
   parameter int GATE_LEN = 256,
   parameter int THRESHOLD = 128
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_st,
   input  logic                       i_rd_empty,
   input  logic [2*AD_DATA_WIDTH-1:0] i_dual_data,
   output logic                       o_busy,
   output logic                       o_done,
   output logic                       o_found,
   output logic [AD_DATA_WIDTH-1:0]   o_peak,
   output logic [IDX_WIDTH-1:0]       o_peak_idx,
   output logic [IDX_WIDTH-1:0]       o_first_idx
);
   localparam int W = AD_DATA_WIDTH;
   localparam logic [IDX_WIDTH-1:0] LAST = IDX_WIDTH'(GATE_START + GATE_LEN - 1);
   localparam logic [IDX_WIDTH-1:0] PRE = IDX_WIDTH'(GATE_START - 1);

   if (GATE_LEN < 1 || GATE_START + GATE_LEN >= 2 ** IDX_WIDTH) begin : g_bad_cfg
      $error("echo_gate_peak: gate window does not fit the index width");
   end

   state_t               state, state_nx;
   logic [IDX_WIDTH-1:0] n, n1, n2, w_idx, w_first, c_idx, c_first;
   logic [W-1:0]         w_peak, c_peak;
   logic                 w_found, w_have, c_found, c_have, take, hit_pre, hit_last;

   assign take     = !i_rd_empty && (state == SKIP || state == GATE);
   assign n1       = &n ? n : n + 1'b1;
   assign n2       = (n >= ~IDX_WIDTH'(1)) ? '1 : n + IDX_WIDTH'(2);
   assign hit_pre  = take && (n == PRE || n1 == PRE);
   assign hit_last = take && (n == LAST || n1 == LAST);
   assign o_busy   = (state == SKIP) || (state == GATE);
   assign o_done   = (state == DONE);

   pair_max_cmp #(.W(W), .IW(IDX_WIDTH), .THRESHOLD(THRESHOLD)) u_cmp (
      .s0(i_dual_data[W-1:0]),
      .s1(i_dual_data[2*W-1:W]),
      .k0(n),
      .k1(n1),
      .g0(gated(32'(n), GATE_START, GATE_LEN)),
      .g1(gated(32'(n1), GATE_START, GATE_LEN)),
      .peak(w_peak),
      .peak_idx(w_idx),
      .first_idx(w_first),
      .found(w_found),
      .have(w_have),
      .peak_nx(c_peak),
      .idx_nx(c_idx),
      .first_nx(c_first),
      .found_nx(c_found),
      .have_nx(c_have)
   );

   // gating is decided per sample index, so SKIP/GATE only steer the transitions
   always_comb begin
      state_nx = i_st ? SKIP :
                 state == DONE ? IDLE :
                 hit_last ? DONE :
                 (state == SKIP && (GATE_START == 0 || hit_pre)) ? GATE : state;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= IDLE;
      else state <= state_nx;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         n           <= '0;
         w_peak      <= '0;
         w_idx       <= '0;
         w_first     <= '0;
         w_found     <= 1'b0;
         w_have      <= 1'b0;
         o_peak      <= '0;
         o_peak_idx  <= '0;
         o_first_idx <= '0;
         o_found     <= 1'b0;
      end else if (i_st) begin
         n       <= '0;
         w_peak  <= '0;
         w_idx   <= '0;
         w_first <= '0;
         w_found <= 1'b0;
         w_have  <= 1'b0;
      end else if (take) begin
         n       <= n2;
         w_peak  <= c_peak;
         w_idx   <= c_idx;
         w_first <= c_first;
         w_found <= c_found;
         w_have  <= c_have;
         // results land on entry to DONE so they are valid while o_done is high
         if (hit_last) begin
            o_peak      <= c_peak;
            o_peak_idx  <= c_idx;
            o_first_idx <= c_first;
            o_found     <= c_found;
         end
      end
   end

endmodule

// File: tb/tb_echo_gate_peak.sv
// tb_echo_gate_peak: directed runs on a default and a narrow-gate instance, scoreboarded results.
module tb_echo_gate_peak;

   typedef struct packed {
      logic [7:0]  peak;
      logic [15:0] idx;
      logic [15:0] first;
      logic        found;
   } res_t;

   logic        clk = 0, rst, st_a, st_b, empty;
   logic [15:0] data;
   logic        busy_a, done_a, found_a, busy_b, done_b, found_b;
   logic [7:0]  peak_a, peak_b;
   logic [15:0] pidx_a, first_a, pidx_b, first_b;
   int          checks = 0, errors = 0;
   res_t        qa[$], qb[$];
   res_t        last_a = '0;

   always #5 clk = ~clk;

   echo_gate_peak dut_a (
      .i_clk(clk), .i_rst(rst), .i_st(st_a), .i_rd_empty(empty), .i_dual_data(data),
      .o_busy(busy_a), .o_done(done_a), .o_found(found_a), .o_peak(peak_a),
      .o_peak_idx(pidx_a), .o_first_idx(first_a)
   );

   echo_gate_peak #(.GATE_START(15), .GATE_LEN(3)) dut_b (
      .i_clk(clk), .i_rst(rst), .i_st(st_b), .i_rd_empty(empty), .i_dual_data(data),
      .o_busy(busy_b), .o_done(done_b), .o_found(found_b), .o_peak(peak_b),
      .o_peak_idx(pidx_b), .o_first_idx(first_b)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] samp(input int mode, input int k);
      return mode == 0 ? 8'(k) : mode == 1 ? 8'd50 : 8'(k * 37 + 11);
   endfunction

   function automatic res_t model(input int mode, input int gs, input int len);
      res_t r;
      bit have;
      logic [7:0] s;
      r = '0;
      have = 0;
      for (int k = gs; k < gs + len; k++) begin
         s = samp(mode, k);
         if (!have || s > r.peak) begin
            r.peak = s;
            r.idx = 16'(k);
            have = 1;
         end
         if (!r.found && s >= 8'd128) begin
            r.found = 1'b1;
            r.first = 16'(k);
         end
      end
      return r;
   endfunction

   task automatic cmp_res(input string tag, input logic [7:0] p, input logic [15:0] i,
                          input logic [15:0] f, input logic fd, input res_t e);
      chk({tag, "_peak"}, 32'(p), 32'(e.peak));
      chk({tag, "_peak_idx"}, 32'(i), 32'(e.idx));
      chk({tag, "_first_idx"}, 32'(f), 32'(e.first));
      chk({tag, "_found"}, 32'(fd), 32'(e.found));
   endtask

   always @(negedge clk) if (done_a) begin
      if (qa.size() == 0) chk("unexpected_done_a", 1, 0);
      else begin
         last_a = qa.pop_front();
         cmp_res("res_a", peak_a, pidx_a, first_a, found_a, last_a);
      end
   end

   always @(negedge clk) if (done_b) begin
      if (qb.size() == 0) chk("unexpected_done_b", 1, 0);
      else cmp_res("res_b", peak_b, pidx_b, first_b, found_b, qb.pop_front());
   end

   // abort >= 0 stops feeding once that index is reached (no result expected)
   task automatic run(input bit sel, input int mode, input int stall, input int gs, input int len,
                      input int abort, input bit pre, input bit chain);
      int  k, last;
      bit  fin, quit;
      k = 0;
      last = gs + len - 1;
      fin = 0;
      quit = 0;
      if (abort < 0) begin
         if (sel) qb.push_back(model(mode, gs, len));
         else qa.push_back(model(mode, gs, len));
      end
      if (!pre) begin
         @(negedge clk);
         empty = 1;
         if (sel) st_b = 1; else st_a = 1;
         @(negedge clk);
         st_a = 0;
         st_b = 0;
      end
      chk("busy_start", 32'(sel ? busy_b : busy_a), 1);
      for (int c = 0; c < 4000 && !fin && !quit; c++) begin
         if (abort >= 0 && k >= abort) quit = 1;
         else begin
            empty = ($urandom_range(0, 99) < stall);
            data = {samp(mode, k + 1), samp(mode, k)};
            @(negedge clk);
            if (!empty && k + 1 >= last) begin
               chk("done_latency", 32'(sel ? done_b : done_a), 1);
               chk("busy_in_done", 32'(sel ? busy_b : busy_a), 0);
               fin = 1;
               if (chain) st_a = 1;
               @(negedge clk);
               st_a = 0;
               chk("done_width", 32'(sel ? done_b : done_a), 0);
            end else begin
               chk("no_early_done", 32'(sel ? done_b : done_a), 0);
               chk("busy", 32'(sel ? busy_b : busy_a), 1);
               if (!empty) k += 2;
            end
         end
      end
      empty = 1;
      if (!fin && !quit) chk("timeout", 0, 1);
   endtask

   initial begin
      rst = 1;
      st_a = 0;
      st_b = 0;
      empty = 1;
      data = '0;
      repeat (3) @(negedge clk);
      cmp_res("reset", peak_a, pidx_a, first_a, found_a, '0);
      chk("reset_busy", 32'(busy_a), 0);
      chk("reset_done", 32'(done_a), 0);
      rst = 0;
      run(0, 0, 0, 16, 256, -1, 0, 0);
      run(0, 1, 0, 16, 256, -1, 0, 0);
      run(1, 0, 0, 15, 3, -1, 0, 0);
      run(0, 0, 50, 16, 256, -1, 0, 0);
      run(0, 2, 30, 16, 256, -1, 0, 1);
      run(0, 0, 0, 16, 256, -1, 1, 0);
      run(0, 0, 0, 16, 256, 100, 0, 0);
      cmp_res("held", peak_a, pidx_a, first_a, found_a, last_a);
      run(0, 1, 0, 16, 256, -1, 0, 0);
      run(0, 2, 0, 16, 256, 6, 0, 0);
      @(negedge clk);
      rst = 1;
      #1;
      chk("rst_busy", 32'(busy_a), 0);
      chk("rst_done", 32'(done_a), 0);
      cmp_res("rst_mid", peak_a, pidx_a, first_a, found_a, '0);
      @(negedge clk);
      rst = 0;
      run(0, 2, 20, 16, 256, -1, 0, 0);
      repeat (3) @(negedge clk);
      chk("queue_a_drained", qa.size(), 0);
      chk("queue_b_drained", qb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
